// File: rtl/doorlock_entry_ctrl.sv
// Keypad entry sequencer for the doorlock: drives the digit register bank,
// checks the entry against the stored password and handles unlock/lockout.
module doorlock_entry_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int MAX_FAIL       = 3,
    parameter int UNLOCK_CYCLES  = 50,
    parameter int LOCKOUT_CYCLES = 200,
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              key_valid,
    input  logic [3:0]                        key_code,
    input  logic [4*NUM_DIGITS-1:0]           pw,
    input  logic [4*NUM_DIGITS-1:0]           entry_q,
    output logic [3:0]                        reg_din,
    output logic [NUM_DIGITS-1:0]             reg_ce,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_cnt,
    output logic                              unlock,
    output logic                              err,
    output logic                              alarm,
    output logic [2:0]                        state
);

    localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int TMAX_A = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMAX   = (TMAX_A > TIMEOUT_CYCLES) ? TMAX_A : TIMEOUT_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [CNT_W-1:0]      CNT_FULL     = CNT_W'(NUM_DIGITS);
    localparam logic [CNT_W-1:0]      CNT_ONE      = CNT_W'(1);
    localparam logic [FAIL_W-1:0]     FAIL_LAST    = FAIL_W'(MAX_FAIL - 1);
    localparam logic [FAIL_W-1:0]     FAIL_ONE     = FAIL_W'(1);
    localparam logic [TW-1:0]         TO_LAST      = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]         UNLOCK_LAST  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0]         LOCK_LAST    = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0]         TIMER_ONE    = TW'(1);
    localparam logic [NUM_DIGITS-1:0] CE_ONE       = NUM_DIGITS'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_FAIL    = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_digit_cnt;
    logic [FAIL_W-1:0]       r_fail_cnt;
    logic [TW-1:0]           r_timer;
    logic [NUM_DIGITS-1:0]   r_reg_ce;
    logic [3:0]              r_reg_din;
    logic                    r_unlock;
    logic                    r_err;
    logic                    r_alarm;

    logic w_digit;
    logic w_clear;
    logic w_enter;
    logic w_match;

    assign w_digit = key_valid && (key_code <= 4'd9);
    assign w_clear = key_valid && (key_code == 4'hA);
    assign w_enter = key_valid && (key_code == 4'hB);
    assign w_match = (r_digit_cnt == CNT_FULL) && (entry_q == pw);

    // Entry FSM with registered bank controls, status outputs and timers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_digit_cnt <= {CNT_W{1'b0}};
            r_fail_cnt  <= {FAIL_W{1'b0}};
            r_timer     <= {TW{1'b0}};
            r_reg_ce    <= {NUM_DIGITS{1'b0}};
            r_reg_din   <= 4'd0;
            r_unlock    <= 1'b0;
            r_err       <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            r_reg_ce  <= {NUM_DIGITS{1'b0}};
            r_reg_din <= 4'd0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_digit) begin
                        r_reg_ce    <= CE_ONE;
                        r_reg_din   <= key_code;
                        r_digit_cnt <= CNT_ONE;
                        r_timer     <= {TW{1'b0}};
                        r_state     <= S_ENTRY;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ENTRY: begin
                    if (w_digit) begin
                        r_timer <= {TW{1'b0}};
                        if (r_digit_cnt < CNT_FULL) begin
                            r_reg_ce    <= CE_ONE << r_digit_cnt;
                            r_reg_din   <= key_code;
                            r_digit_cnt <= r_digit_cnt + CNT_ONE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else if (w_clear) begin
                        r_digit_cnt <= {CNT_W{1'b0}};
                        r_timer     <= {TW{1'b0}};
                        r_state     <= S_IDLE;
                    end else if (w_enter) begin
                        r_timer <= {TW{1'b0}};
                        r_state <= S_CHECK;
                    end else if (r_timer == TO_LAST) begin
                        r_digit_cnt <= {CNT_W{1'b0}};
                        r_timer     <= {TW{1'b0}};
                        r_state     <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TIMER_ONE;
                    end
                end
                S_CHECK: begin
                    r_digit_cnt <= {CNT_W{1'b0}};
                    r_timer     <= {TW{1'b0}};
                    if (w_match) begin
                        r_fail_cnt <= {FAIL_W{1'b0}};
                        r_unlock   <= 1'b1;
                        r_state    <= S_OPEN;
                    end else if (r_fail_cnt == FAIL_LAST) begin
                        r_alarm <= 1'b1;
                        r_state <= S_LOCKOUT;
                    end else begin
                        r_fail_cnt <= r_fail_cnt + FAIL_ONE;
                        r_err      <= 1'b1;
                        r_state    <= S_FAIL;
                    end
                end
                S_FAIL: begin
                    r_state <= S_IDLE;
                end
                S_OPEN: begin
                    if (r_timer == UNLOCK_LAST) begin
                        r_timer  <= {TW{1'b0}};
                        r_unlock <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TIMER_ONE;
                    end
                end
                S_LOCKOUT: begin
                    if (r_timer == LOCK_LAST) begin
                        r_timer    <= {TW{1'b0}};
                        r_alarm    <= 1'b0;
                        r_fail_cnt <= {FAIL_W{1'b0}};
                        r_state    <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TIMER_ONE;
                    end
                end
                default: begin
                    r_digit_cnt <= {CNT_W{1'b0}};
                    r_timer     <= {TW{1'b0}};
                    r_unlock    <= 1'b0;
                    r_alarm     <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign reg_ce    = r_reg_ce;
    assign reg_din   = r_reg_din;
    assign digit_cnt = r_digit_cnt;
    assign unlock    = r_unlock;
    assign err       = r_err;
    assign alarm     = r_alarm;
    assign state     = r_state;

endmodule
